// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM with fixed wait states and byte-lane writes.
// Define AHBL_SRAM_ERR_EN to issue ERROR for out-of-range, oversize or misaligned transfers.
module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W     = $clog2(NUM_BYTES);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_BYTES-1:0]  mask_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  start;
  logic                  addr_err;
  logic                  commit;
  logic [IDX_W-1:0]      addr_idx;
  logic [NUM_BYTES-1:0]  addr_mask;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_inputs;

  // Lanes enabled are the naturally aligned 2^size block containing the offset; oversize
  // transfers are clamped to the full bus width.
  function automatic logic [NUM_BYTES-1:0] lane_mask(logic [2:0] size, logic [OFF_W-1:0] off);
    logic [2:0]           es;
    logic [NUM_BYTES-1:0] m;
    es = (size > 3'(OFF_W)) ? 3'(OFF_W) : size;
    m  = '0;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      m[b] = ((b >> es) == (32'(off) >> es));
    end
    return m;
  endfunction

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign start     = accept & (state_q inside {StIdle, StData, StErr2});
  assign addr_idx  = HADDR[OFF_W +: IDX_W];
  assign addr_mask = lane_mask(HSIZE, HADDR[OFF_W-1:0]);
  assign commit    = (state_q == StData) & write_q;

`ifdef AHBL_SRAM_ERR_EN
  always_comb begin
    addr_err = 1'b0;
    if ((HADDR >> (OFF_W + IDX_W)) != '0) begin
      addr_err = 1'b1;
    end
    if (HSIZE > 3'(OFF_W)) begin
      addr_err = 1'b1;
    end else if ((32'(HADDR[OFF_W-1:0]) & ((32'd1 << HSIZE) - 32'd1)) != 32'd0) begin
      addr_err = 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StData, StErr2: begin
        state_d = StIdle;
        if (start) begin
          if (addr_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES == 0) begin
            state_d = StData;
          end else begin
            state_d = StWait;
            cnt_d   = 3'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        if (cnt_q <= 3'd1) begin
          state_d = StData;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // Read word is latched on entry to DATA; a write retiring on the same edge is merged in.
  always_comb begin
    rd_idx  = start ? addr_idx : idx_q;
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (mask_q[b]) begin
          rd_word[8*b +: 8] = HWDATA[8*b +: 8];
        end
      end
    end
    rdata_d = rdata_q;
    if ((state_d == StData) && (start || (state_q == StWait))) begin
      rdata_d = rd_word;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (start) begin
        idx_q   <= addr_idx;
        mask_q  <= addr_mask;
        write_q <= HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (mask_q[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    unique case (state_q)
      StWait:  HREADYOUT = 1'b0;
      StData:  HRDATA    = rdata_q;
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2:  HRESP     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: three instances (0, 2, 3 wait states) on a shared bus,
// a transaction-level reference model compared every cycle, plus literal spot checks.
module tb_ahb_lite_sram_slave;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [2:0]  hreadyout;
  logic [2:0]  hresp;
  logic [31:0] hrdata [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_lite_sram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (1024),
      .WAIT_STATES((g == 0) ? 0 : g + 1)
    ) u_dut (
      .HCLK     (clk),
      .HRESETn  (rst_n),
      .HSEL     (hsel[g]),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (3'b000),
      .HPROT    (4'b0011),
      .HMASTLOCK(1'b0),
      .HWDATA   (hwdata),
      .HREADY   (hreadyout[g]),
      .HRDATA   (hrdata[g]),
      .HREADYOUT(hreadyout[g]),
      .HRESP    (hresp[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, d, got, want);
    end
  endtask

  // Reference model: one outstanding data phase per instance, timed in cycles since accept.
  bit          act   [3];
  bit          merr  [3];
  bit          mwr   [3];
  int          el    [3];
  int          midx  [3];
  logic [3:0]  mmask [3];
  logic [31:0] mm    [3][1024];
  bit          kn    [3][1024];

  function automatic bit model_ready(input int d);
    if (!act[d]) return 1'b1;
    if (merr[d]) return el[d] == 1;
    return el[d] == ws_of(d);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          act[d] = 1'b0;
        end else begin
          bit          r;
          logic [31:0] a;
          int          sz;
          int          nb;
          int          base;
          r = model_ready(d);
          if (act[d]) begin
            if (r) begin
              if (!merr[d] && mwr[d]) begin
                for (int b = 0; b < 4; b++)
                  if (mmask[d][b]) mm[d][midx[d]][8*b +: 8] = hwdata[8*b +: 8];
                if (mmask[d] == 4'hF) kn[d][midx[d]] = 1'b1;
              end
              act[d] = 1'b0;
            end else begin
              el[d]++;
            end
          end
          if (r && hsel[d] && htrans[1]) begin
            a = haddr;
`ifdef AHBL_SRAM_ERR_EN
            merr[d] = (a >= 32'h1000) || (hsize > 3'd2) || ((a % (32'd1 << hsize)) != 0);
`else
            merr[d] = 1'b0;
`endif
            sz       = (hsize > 3'd2) ? 2 : int'(hsize);
            nb       = 1 << sz;
            base     = (int'(a % 4) / nb) * nb;
            mmask[d] = 4'(((1 << nb) - 1) << base);
            midx[d]  = int'((a / 4) % 1024);
            mwr[d]   = hwrite;
            el[d]    = 0;
            act[d]   = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 3; d++) begin
          chk("hreadyout", d, 32'(hreadyout[d]), 32'(model_ready(d)));
          chk("hresp", d, 32'(hresp[d]), 32'(act[d] && merr[d]));
          if (!act[d] || merr[d]) begin
            chk("hrdata_zero", d, hrdata[d], 32'h0);
          end else if (!mwr[d] && (el[d] == ws_of(d)) && kn[d][midx[d]]) begin
            chk("hrdata", d, hrdata[d], mm[d][midx[d]]);
          end
        end
      end
    end
  end

  // Pipelined master operating on a small op table.
  logic        op_wr    [8];
  logic [31:0] op_addr  [8];
  logic [2:0]  op_size  [8];
  logic [31:0] op_data  [8];
  logic [31:0] op_rd    [8];
  int          op_waits [8];
  logic        op_err   [8];

  task automatic set_op(input int i, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] dat);
    op_wr[i]   = wr;
    op_addr[i] = a;
    op_size[i] = sz;
    op_data[i] = dat;
  endtask

  task automatic drive_addr(input int d, input int i);
    hsel    = 3'b000;
    hsel[d] = 1'b1;
    haddr   = op_addr[i];
    hwrite  = op_wr[i];
    hsize   = op_size[i];
    htrans  = 2'b10;
  endtask

  task automatic run(input int d, input int n);
    int   a;
    int   dp;
    int   adr_idx;
    int   budget;
    logic adr_act;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      op_rd[i]    = '0;
      op_waits[i] = 0;
      op_err[i]   = 1'b0;
    end
    dp = -1;
    drive_addr(d, 0);
    adr_idx = 0;
    adr_act = 1'b1;
    a       = 1;
    for (budget = 0; budget < 200; budget++) begin
      rdy = hreadyout[d];
      if (dp >= 0) begin
        if (!rdy) op_waits[dp]++;
        if (hresp[d]) op_err[dp] = 1'b1;
        if (rdy) op_rd[dp] = hrdata[d];
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        dp = adr_act ? adr_idx : -1;
        if (a < n) begin
          drive_addr(d, a);
          adr_idx = a;
          a++;
        end else begin
          htrans  = 2'b00;
          adr_act = 1'b0;
        end
        if (dp >= 0) hwdata = op_data[dp];
      end
      if (dp < 0 && !adr_act) break;
    end
    hsel = 3'b000;
    chk("run_timeout", d, 32'(budget >= 200), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    hsel   = 3'b000;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_hreadyout", d, 32'(hreadyout[d]), 32'd1);
      chk("rst_hresp", d, 32'(hresp[d]), 32'd0);
      chk("rst_hrdata", d, hrdata[d], 32'h0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait write then back-to-back read of the same word.
    set_op(0, 1'b1, 32'h20, 3'd2, 32'hDEADBEEF);
    set_op(1, 1'b0, 32'h20, 3'd2, 32'h0);
    run(0, 2);
    chk("fwd_rdata", 0, op_rd[1], 32'hDEADBEEF);
    chk("fwd_waits", 0, 32'(op_waits[1]), 32'd0);

    // Byte and halfword lanes over a zeroed word.
    set_op(0, 1'b1, 32'h40, 3'd2, 32'h00000000);
    set_op(1, 1'b1, 32'h40, 3'd0, 32'h00000011);
    set_op(2, 1'b1, 32'h42, 3'd1, 32'h22330000);
    set_op(3, 1'b0, 32'h40, 3'd2, 32'h0);
    run(0, 4);
    chk("lanes_rdata", 0, op_rd[3], 32'h22330011);

    // Two wait states on both write and read.
    set_op(0, 1'b1, 32'h8, 3'd2, 32'hCAFEF00D);
    set_op(1, 1'b0, 32'h8, 3'd2, 32'h0);
    run(1, 2);
    chk("ws2_wr_waits", 1, 32'(op_waits[0]), 32'd2);
    chk("ws2_rd_waits", 1, 32'(op_waits[1]), 32'd2);
    chk("ws2_rdata", 1, op_rd[1], 32'hCAFEF00D);
    chk("ws2_resp", 1, 32'(op_err[1]), 32'd0);

    // Asynchronous reset in the middle of a three-wait-state write.
    set_op(0, 1'b1, 32'h10, 3'd2, 32'h00000000);
    run(2, 1);
    hsel   = 3'b100;
    haddr  = 32'h10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    htrans = 2'b10;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    hwdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    chk("midwait_hreadyout", 2, 32'(hreadyout[2]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hreadyout", 2, 32'(hreadyout[2]), 32'd1);
    chk("async_hresp", 2, 32'(hresp[2]), 32'd0);
    chk("async_hrdata", 2, hrdata[2], 32'h0);
    hsel = 3'b000;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_op(0, 1'b0, 32'h10, 3'd2, 32'h0);
    run(2, 1);
    chk("dropped_write", 2, op_rd[0], 32'h00000000);
    chk("ws3_waits", 2, 32'(op_waits[0]), 32'd3);

`ifdef AHBL_SRAM_ERR_EN
    set_op(0, 1'b1, 32'h0, 3'd2, 32'h12345678);
    set_op(1, 1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF);
    set_op(2, 1'b0, 32'h0, 3'd2, 32'h0);
    set_op(3, 1'b1, 32'h3, 3'd1, 32'hFFFFFFFF);
    run(0, 4);
    chk("ok_no_err", 0, 32'(op_err[0]), 32'd0);
    chk("range_err", 0, 32'(op_err[1]), 32'd1);
    chk("err1_len", 0, 32'(op_waits[1]), 32'd1);
    chk("err_no_write", 0, op_rd[2], 32'h12345678);
    chk("align_err", 0, 32'(op_err[3]), 32'd1);
`else
    set_op(0, 1'b1, 32'h1004, 3'd2, 32'hA5A5A5A5);
    set_op(1, 1'b0, 32'h4, 3'd2, 32'h0);
    set_op(2, 1'b1, 32'h52, 3'd2, 32'h01020304);
    set_op(3, 1'b0, 32'h50, 3'd2, 32'h0);
    run(0, 4);
    chk("wrap_ok", 0, 32'(op_err[0]), 32'd0);
    chk("wrap_rdata", 0, op_rd[1], 32'hA5A5A5A5);
    chk("misalign_cleared", 0, op_rd[3], 32'h01020304);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
